dual_issue_dispatcher: RTL and testbench

- Initiator side of the register-renew protocol.
- Takes a decoded instruction stream (valid/ready) and issues each instruction to processor 1 or processor 2.
- Drives the boot_renew_register_1/2 and register_num handshake into the registers management block.
- Consumes that block's processing_register_table and synchronized_processors to block RAW/WAW hazards and honour barrier instructions.

---
 rtl/dual_issue_dispatcher_pkg.sv | 15 +
 rtl/dual_issue_dispatcher_if.sv | 23 ++
 rtl/dual_issue_dispatcher_tracker.sv | 32 +++
 rtl/dual_issue_dispatcher.sv | 131 +++++++++++++
 tb/tb_dual_issue_dispatcher.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_dispatcher_pkg.sv
// Shared state encodings for the dual-issue dispatcher and its per-processor trackers.
package dispatcher_pkg;

    typedef enum logic {
        RUN,
        DRAIN
    } disp_state_t;

    typedef enum logic [1:0] {
        FREE,
        WAIT_START,
        WAIT_DONE
    } tracker_state_t;

endpackage

// File: rtl/dual_issue_dispatcher_if.sv
// Decoded instruction stream handshake: the master offers instructions, the dispatcher accepts on valid&ready.
interface dual_issue_dispatcher_if #(
    parameter int REG_CTN_WIDTH = 5,
    parameter int INSTR_WIDTH   = 32
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [INSTR_WIDTH-1:0]   instr_payload;
    logic [REG_CTN_WIDTH-1:0] instr_rd;
    logic [REG_CTN_WIDTH-1:0] instr_rs1;
    logic [REG_CTN_WIDTH-1:0] instr_rs2;
    logic                     instr_barrier;

    modport master (
        output instr_valid, instr_payload, instr_rd, instr_rs1, instr_rs2, instr_barrier,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_payload, instr_rd, instr_rs1, instr_rs2, instr_barrier,
        output instr_ready
    );
endinterface

// File: rtl/dual_issue_dispatcher_tracker.sv
// Busy tracker for one processor: FREE until dispatched, then waits for the idle line to fall and rise again.
module processor_tracker
    import dispatcher_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic dispatch,
    input  logic processor_idle,
    output logic free
);

    tracker_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FREE;
        else        state <= state_nxt;
    end

    // Idle still high right after a dispatch means the processor has not started yet.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE:       if (dispatch)        state_nxt = WAIT_START;
            WAIT_START: if (!processor_idle) state_nxt = WAIT_DONE;
            WAIT_DONE:  if (processor_idle)  state_nxt = FREE;
            default:                         state_nxt = FREE;
        endcase
    end

    assign free = (state == FREE);

endmodule

// File: rtl/dual_issue_dispatcher.sv
// Issues decoded instructions to processor 1/2 with RAW/WAW hazard blocking and barrier draining; 1-cycle dispatch latency.
// Optional saturating statistics counters under DUAL_ISSUE_DISPATCH_STATS_EN.
module dual_issue_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
    parameter int INSTR_WIDTH     = 32
`ifdef DUAL_ISSUE_DISPATCH_STATS_EN
    ,
    parameter int STAT_WIDTH      = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dual_issue_dispatcher_if.slave     instr,
    input  logic [0:REGISTER_AMOUNT-1] processing_register_table,
    input  logic                       synchronized_processors,
    input  logic                       processor_idle_1,
    input  logic                       processor_idle_2,
    output logic                       boot_renew_register_1,
    output logic                       boot_renew_register_2,
    output logic [REG_CTN_WIDTH-1:0]   register_num,
    output logic [INSTR_WIDTH-1:0]     dispatch_payload_1,
    output logic [INSTR_WIDTH-1:0]     dispatch_payload_2,
    output logic                       dispatcher_draining
`ifdef DUAL_ISSUE_DISPATCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]      dispatch_count_1,
    output logic [STAT_WIDTH-1:0]      dispatch_count_2,
    output logic [STAT_WIDTH-1:0]      hazard_stall_count
`endif
);

    disp_state_t                state, state_nxt;
    logic                       free_1, free_2;
    logic                       ready_comb, fire, dispatch_1, dispatch_2;
    logic                       hazard;
    logic [0:REGISTER_AMOUNT-1] inflight, hazard_mask;

    // The table bit only sets a cycle after the boot pulse, so the pulsing rd is masked here meanwhile.
    always_comb begin
        inflight = '0;
        if (boot_renew_register_1 || boot_renew_register_2) inflight[register_num] = 1'b1;
    end

    assign hazard_mask = processing_register_table | inflight;
    assign hazard = ((instr.instr_rs1 != '0) && hazard_mask[instr.instr_rs1]) ||
                    ((instr.instr_rs2 != '0) && hazard_mask[instr.instr_rs2]) ||
                    ((instr.instr_rd  != '0) && hazard_mask[instr.instr_rd]);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ready_comb = 1'b0;
        case (state)
            RUN: begin
                ready_comb = instr.instr_valid && !instr.instr_barrier && !hazard && (free_1 || free_2);
                if (instr.instr_valid && instr.instr_barrier) state_nxt = DRAIN;
            end
            DRAIN: begin
                ready_comb = free_1 && free_2 && (processing_register_table == '0) &&
                             !boot_renew_register_1 && !boot_renew_register_2 && synchronized_processors;
                if (instr.instr_valid && ready_comb) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign instr.instr_ready   = rst_n && ready_comb;
    assign fire                = instr.instr_valid && instr.instr_ready;
    assign dispatch_1          = fire && free_1;
    assign dispatch_2          = fire && !free_1;
    assign dispatcher_draining = (state == DRAIN);

    processor_tracker u_tracker_1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .dispatch       (dispatch_1),
        .processor_idle (processor_idle_1),
        .free           (free_1)
    );

    processor_tracker u_tracker_2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .dispatch       (dispatch_2),
        .processor_idle (processor_idle_2),
        .free           (free_2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            boot_renew_register_1 <= 1'b0;
            boot_renew_register_2 <= 1'b0;
            register_num          <= '0;
            dispatch_payload_1    <= '0;
            dispatch_payload_2    <= '0;
        end else begin
            boot_renew_register_1 <= dispatch_1;
            boot_renew_register_2 <= dispatch_2;
            if (fire)       register_num       <= instr.instr_rd;
            if (dispatch_1) dispatch_payload_1 <= instr.instr_payload;
            if (dispatch_2) dispatch_payload_2 <= instr.instr_payload;
        end
    end

`ifdef DUAL_ISSUE_DISPATCH_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dispatch_count_1   <= '0;
            dispatch_count_2   <= '0;
            hazard_stall_count <= '0;
        end else begin
            if (boot_renew_register_1 && (dispatch_count_1 != '1))
                dispatch_count_1 <= dispatch_count_1 + STAT_ONE;
            if (boot_renew_register_2 && (dispatch_count_2 != '1))
                dispatch_count_2 <= dispatch_count_2 + STAT_ONE;
            if (instr.instr_valid && (state == RUN) && hazard && (hazard_stall_count != '1))
                hazard_stall_count <= hazard_stall_count + STAT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// Directed table-driven bench for dual_issue_dispatcher plus a hand-written mid-pulse reset sequence.
module tb_dual_issue_dispatcher;

    localparam int RA = 32;
    localparam int RW = 5;
    localparam int IW = 32;
    localparam int NV = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:RA-1] tbl;
    logic          sync, idle1, idle2;
    logic          b1, b2, drain;
    logic [RW-1:0] rn;
    logic [IW-1:0] p1, p2;

    always #5 clk = ~clk;

    dual_issue_dispatcher_if #(.REG_CTN_WIDTH(RW), .INSTR_WIDTH(IW)) ifc ();

    dual_issue_dispatcher #(
        .REGISTER_AMOUNT (RA),
        .REG_CTN_WIDTH   (RW),
        .INSTR_WIDTH     (IW)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .instr                     (ifc),
        .processing_register_table (tbl),
        .synchronized_processors   (sync),
        .processor_idle_1          (idle1),
        .processor_idle_2          (idle2),
        .boot_renew_register_1     (b1),
        .boot_renew_register_2     (b2),
        .register_num              (rn),
        .dispatch_payload_1        (p1),
        .dispatch_payload_2        (p2),
        .dispatcher_draining       (drain)
    );

    typedef struct {
        logic          valid, barrier;
        logic [RW-1:0] rd, rs1, rs2;
        logic [IW-1:0] pay;
        int            tbit;
        logic          idle1, idle2, sync;
        logic          e_ready, e_b1, e_b2;
        logic [RW-1:0] e_rn;
        logic          e_drain;
        logic [IW-1:0] e_p1, e_p2;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(int v, int bar, int rd, int r1, int r2, int pay, int tb,
                                int i1, int i2, int sy, int er, int eb1, int eb2,
                                int ern, int edr, int ep1, int ep2);
        vec_t r;
        r.valid = 1'(v);    r.barrier = 1'(bar);
        r.rd = RW'(rd);     r.rs1 = RW'(r1);      r.rs2 = RW'(r2);
        r.pay = IW'(pay);   r.tbit = tb;
        r.idle1 = 1'(i1);   r.idle2 = 1'(i2);     r.sync = 1'(sy);
        r.e_ready = 1'(er); r.e_b1 = 1'(eb1);     r.e_b2 = 1'(eb2);
        r.e_rn = RW'(ern);  r.e_drain = 1'(edr);
        r.e_p1 = IW'(ep1);  r.e_p2 = IW'(ep2);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_instr(input logic v, input logic bar, input int rd, input int r1,
                               input int r2, input int pay);
        ifc.instr_valid   = v;
        ifc.instr_barrier = bar;
        ifc.instr_rd      = RW'(rd);
        ifc.instr_rs1     = RW'(r1);
        ifc.instr_rs2     = RW'(r2);
        ifc.instr_payload = IW'(pay);
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        drive_instr(t.valid, t.barrier, int'(t.rd), int'(t.rs1), int'(t.rs2), int'(t.pay));
        tbl = '0;
        if (t.tbit >= 0) tbl[t.tbit] = 1'b1;
        idle1 = t.idle1;
        idle2 = t.idle2;
        sync  = t.sync;
        #1;
        chk($sformatf("v%0d.ready", idx), 32'(ifc.instr_ready), 32'(t.e_ready));
        chk($sformatf("v%0d.boot1", idx), 32'(b1),    32'(t.e_b1));
        chk($sformatf("v%0d.boot2", idx), 32'(b2),    32'(t.e_b2));
        chk($sformatf("v%0d.regnum", idx), 32'(rn),   32'(t.e_rn));
        chk($sformatf("v%0d.drain", idx), 32'(drain), 32'(t.e_drain));
        chk($sformatf("v%0d.pay1", idx), p1,          t.e_p1);
        chk($sformatf("v%0d.pay2", idx), p2,          t.e_p2);
        chk($sformatf("v%0d.boot_excl", idx), 32'(b1 & b2), 32'(0));
    endtask

    initial begin
        //                v  bar rd  r1  r2  pay    tb  i1 i2 sy  rdy b1 b2 rn  dr  p1     p2
        vecs[0]  = mk(1, 0,  5,  2,  3, 'hA1,  -1, 1, 1, 1,  1, 0, 0,  0, 0, 'h00, 'h00);
        vecs[1]  = mk(1, 0,  6,  7,  8, 'hB2,  -1, 1, 1, 1,  1, 1, 0,  5, 0, 'hA1, 'h00);
        vecs[2]  = mk(0, 0,  0,  0,  0, 'h00,  -1, 0, 0, 1,  0, 0, 1,  6, 0, 'hA1, 'hB2);
        vecs[3]  = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 1, 1,  0, 0, 0,  6, 0, 'hA1, 'hB2);
        vecs[4]  = mk(1, 0,  5,  1,  1, 'hD4,  -1, 1, 1, 1,  1, 0, 0,  6, 0, 'hA1, 'hB2);
        vecs[5]  = mk(1, 0, 10,  5,  0, 'hE5,  -1, 1, 1, 1,  0, 1, 0,  5, 0, 'hD4, 'hB2);
        vecs[6]  = mk(1, 0, 10,  5,  0, 'hE5,   5, 0, 1, 1,  0, 0, 0,  5, 0, 'hD4, 'hB2);
        vecs[7]  = mk(1, 0, 10,  5,  0, 'hE5,   5, 0, 1, 1,  0, 0, 0,  5, 0, 'hD4, 'hB2);
        vecs[8]  = mk(1, 0, 10,  5,  0, 'hE5,  -1, 1, 1, 1,  1, 0, 0,  5, 0, 'hD4, 'hB2);
        vecs[9]  = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 1, 1,  0, 0, 1, 10, 0, 'hD4, 'hE5);
        vecs[10] = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 0, 1,  0, 0, 0, 10, 0, 'hD4, 'hE5);
        vecs[11] = mk(1, 0, 11, 12, 13, 'hF6,  -1, 1, 0, 1,  1, 0, 0, 10, 0, 'hD4, 'hE5);
        vecs[12] = mk(1, 0, 14, 15, 16, 'h77,  -1, 1, 0, 1,  0, 1, 0, 11, 0, 'hF6, 'hE5);
        vecs[13] = mk(1, 0, 14, 15, 16, 'h77,  -1, 1, 0, 1,  0, 0, 0, 11, 0, 'hF6, 'hE5);
        vecs[14] = mk(1, 0, 14, 15, 16, 'h77,  -1, 0, 0, 1,  0, 0, 0, 11, 0, 'hF6, 'hE5);
        vecs[15] = mk(1, 0, 14, 15, 16, 'h77,  -1, 1, 0, 1,  0, 0, 0, 11, 0, 'hF6, 'hE5);
        vecs[16] = mk(1, 0, 14, 15, 16, 'h77,  -1, 1, 0, 1,  1, 0, 0, 11, 0, 'hF6, 'hE5);
        vecs[17] = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 0, 1,  0, 1, 0, 14, 0, 'h77, 'hE5);
        vecs[18] = mk(0, 0,  0,  0,  0, 'h00,  -1, 0, 0, 1,  0, 0, 0, 14, 0, 'h77, 'hE5);
        vecs[19] = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 0, 1,  0, 0, 0, 14, 0, 'h77, 'hE5);
        vecs[20] = mk(1, 1, 20,  0,  0, 'h88,  -1, 1, 0, 0,  0, 0, 0, 14, 0, 'h77, 'hE5);
        vecs[21] = mk(1, 1, 20,  0,  0, 'h88,  -1, 1, 0, 0,  0, 0, 0, 14, 1, 'h77, 'hE5);
        vecs[22] = mk(1, 1, 20,  0,  0, 'h88,  -1, 1, 1, 0,  0, 0, 0, 14, 1, 'h77, 'hE5);
        vecs[23] = mk(1, 1, 20,  0,  0, 'h88,  -1, 1, 1, 0,  0, 0, 0, 14, 1, 'h77, 'hE5);
        vecs[24] = mk(1, 1, 20,  0,  0, 'h88,  -1, 1, 1, 1,  1, 0, 0, 14, 1, 'h77, 'hE5);
        vecs[25] = mk(0, 0,  0,  0,  0, 'h00,  -1, 1, 1, 1,  0, 1, 0, 20, 0, 'h88, 'hE5);

        // Reset with a valid instruction on the bus: nothing may be accepted.
        rst_n = 1'b0;
        drive_instr(1'b1, 1'b0, 5, 2, 3, 'hA1);
        tbl = '0; idle1 = 1'b1; idle2 = 1'b1; sync = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.ready",  32'(ifc.instr_ready), 32'(0));
        chk("rst.boot1",  32'(b1),    32'(0));
        chk("rst.boot2",  32'(b2),    32'(0));
        chk("rst.regnum", 32'(rn),    32'(0));
        chk("rst.pay1",   p1,         32'(0));
        chk("rst.pay2",   p2,         32'(0));
        chk("rst.drain",  32'(drain), 32'(0));
        rst_n = 1'b1;
        drive_instr(1'b0, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) apply(vecs[i], i);

        // Tracker 1 is still WAIT_START, so this goes to processor 2.
        @(negedge clk);
        drive_instr(1'b1, 1'b0, 3, 4, 4, 'h33);
        #1;
        chk("mrst.pre_ready", 32'(ifc.instr_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b0;
        drive_instr(1'b1, 1'b0, 4, 9, 9, 'h55);
        #1;
        chk("mrst.pulse_boot2", 32'(b2), 32'(1));
        chk("mrst.in_rst_ready", 32'(ifc.instr_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst.boot1",  32'(b1),    32'(0));
        chk("mrst.boot2",  32'(b2),    32'(0));
        chk("mrst.regnum", 32'(rn),    32'(0));
        chk("mrst.pay1",   p1,         32'(0));
        chk("mrst.pay2",   p2,         32'(0));
        chk("mrst.drain",  32'(drain), 32'(0));
        chk("mrst.ready",  32'(ifc.instr_ready), 32'(1));
        // Both trackers back to FREE: the fire must go to processor 1.
        @(negedge clk);
        drive_instr(1'b0, 1'b0, 0, 0, 0, 0);
        #1;
        chk("mrst.post_boot1",  32'(b1), 32'(1));
        chk("mrst.post_boot2",  32'(b2), 32'(0));
        chk("mrst.post_regnum", 32'(rn), 32'(4));
        chk("mrst.post_pay1",   p1,      32'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
